baccarat_dealer: RTL and testbench

- Sequential deal controller for one baccarat hand.
- Requests cards from the deck source over a valid/request handshake and loads them into player and banker card slots (P1, D1, P2, D2, then optional P3 and D3).
- Applies the third-card rules, produces per-hand scores using the same face-card-as-zero, mod-10 rule as scorehand, and flags the winner.
- Its card slot outputs drive the scorehand and card7seg inputs downstream.

---
 rtl/baccarat_dealer_if.sv | 12 +
 rtl/baccarat_dealer.sv | 142 ++++++++++++++
 tb/tb_baccarat_dealer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/baccarat_dealer_if.sv
// Deck-source handshake for the baccarat dealer: the dealer raises card_req,
// the deck source answers with card_valid and a card code on card_in.
interface baccarat_dealer_if #(
    parameter int CARD_W = 4
);
    logic              card_valid;
    logic [CARD_W-1:0] card_in;
    logic              card_req;

    modport master (output card_valid, output card_in, input card_req);
    modport slave  (input card_valid, input card_in, output card_req);
endinterface

// File: rtl/baccarat_dealer.sv
// Baccarat hand controller: deals P1 D1 P2 D2 (and optional P3/D3) from the deck
// source, applies the third-card rules and registers the winner flags.
module baccarat_dealer #(
    parameter int CARD_W   = 4,
    parameter int FACE_MIN = 10
) (
    input  logic                slow_clock,
    input  logic                resetb,
    input  logic                start,
    baccarat_dealer_if.slave    deck,
    output logic [CARD_W-1:0]   pcard1,
    output logic [CARD_W-1:0]   pcard2,
    output logic [CARD_W-1:0]   pcard3,
    output logic [CARD_W-1:0]   dcard1,
    output logic [CARD_W-1:0]   dcard2,
    output logic [CARD_W-1:0]   dcard3,
    output logic [3:0]          pscore,
    output logic [3:0]          dscore,
    output logic                player_wins,
    output logic                dealer_wins,
    output logic                done
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
        S_EVAL1, S_DEAL_P3, S_EVAL2, S_DEAL_D3, S_DONE
    } state_t;

    state_t     state;
    logic       accept;
    logic       natural;
    logic [3:0] fin_dscore;

    function automatic logic [3:0] card_val(input logic [CARD_W-1:0] c);
        if (int'(c) >= FACE_MIN) return 4'd0;
        return 4'(c);
    endfunction

    function automatic logic [3:0] hand_score(input logic [CARD_W-1:0] c1,
                                              input logic [CARD_W-1:0] c2,
                                              input logic [CARD_W-1:0] c3);
        logic [4:0] sum;
        sum = {1'b0, card_val(c1)} + {1'b0, card_val(c2)} + {1'b0, card_val(c3)};
        return 4'(sum % 5'd10);
    endfunction

    // Banker third-card tableau, keyed by banker total and the player's third card value.
    function automatic logic banker_draws(input logic [3:0] b, input logic [3:0] t);
        case (b)
            4'd0, 4'd1, 4'd2: return 1'b1;
            4'd3:             return t != 4'd8;
            4'd4:             return (t >= 4'd2) && (t <= 4'd7);
            4'd5:             return (t >= 4'd4) && (t <= 4'd7);
            4'd6:             return (t >= 4'd6) && (t <= 4'd7);
            default:          return 1'b0;
        endcase
    endfunction

    assign pscore  = hand_score(pcard1, pcard2, pcard3);
    assign dscore  = hand_score(dcard1, dcard2, dcard3);
    assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);
    assign accept  = deck.card_req && deck.card_valid &&
                     (deck.card_in != '0) && (int'(deck.card_in) <= 13);

    // The D3 acceptance edge must judge the hand with the card being loaded.
    assign fin_dscore = (state == S_DEAL_D3) ? hand_score(dcard1, dcard2, deck.card_in) : dscore;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state         <= S_IDLE;
            deck.card_req <= 1'b0;
            pcard1 <= '0; pcard2 <= '0; pcard3 <= '0;
            dcard1 <= '0; dcard2 <= '0; dcard3 <= '0;
            player_wins   <= 1'b0;
            dealer_wins   <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    pcard1 <= '0; pcard2 <= '0; pcard3 <= '0;
                    dcard1 <= '0; dcard2 <= '0; dcard3 <= '0;
                    player_wins   <= 1'b0;
                    dealer_wins   <= 1'b0;
                    done          <= 1'b0;
                    deck.card_req <= 1'b1;
                    state         <= S_DEAL_P1;
                end
                S_DEAL_P1: if (accept) begin pcard1 <= deck.card_in; state <= S_DEAL_D1; end
                S_DEAL_D1: if (accept) begin dcard1 <= deck.card_in; state <= S_DEAL_P2; end
                S_DEAL_P2: if (accept) begin pcard2 <= deck.card_in; state <= S_DEAL_D2; end
                S_DEAL_D2: if (accept) begin
                    dcard2        <= deck.card_in;
                    deck.card_req <= 1'b0;
                    state         <= S_EVAL1;
                end
                S_EVAL1: begin
                    if (!natural && pscore <= 4'd5) begin
                        deck.card_req <= 1'b1;
                        state         <= S_DEAL_P3;
                    end else if (!natural && dscore <= 4'd5) begin
                        deck.card_req <= 1'b1;
                        state         <= S_DEAL_D3;
                    end else begin
                        done        <= 1'b1;
                        player_wins <= pscore >= fin_dscore;
                        dealer_wins <= fin_dscore >= pscore;
                        state       <= S_DONE;
                    end
                end
                S_DEAL_P3: if (accept) begin
                    pcard3        <= deck.card_in;
                    deck.card_req <= 1'b0;
                    state         <= S_EVAL2;
                end
                S_EVAL2: begin
                    if (banker_draws(dscore, card_val(pcard3))) begin
                        deck.card_req <= 1'b1;
                        state         <= S_DEAL_D3;
                    end else begin
                        done        <= 1'b1;
                        player_wins <= pscore >= fin_dscore;
                        dealer_wins <= fin_dscore >= pscore;
                        state       <= S_DONE;
                    end
                end
                S_DEAL_D3: if (accept) begin
                    dcard3        <= deck.card_in;
                    deck.card_req <= 1'b0;
                    done          <= 1'b1;
                    player_wins   <= pscore >= fin_dscore;
                    dealer_wins   <= fin_dscore >= pscore;
                    state         <= S_DONE;
                end
                default: begin
                    deck.card_req <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Scoreboard bench for baccarat_dealer: a card-level baccarat model predicts each
// hand, a randomised deck source feeds cards, and a monitor checks every completed hand.
module tb_baccarat_dealer;

    typedef struct {
        int p1, p2, p3, d1, d2, d3;
        int ps, ds, pw, dw, used;
    } exp_t;

    logic       slow_clock;
    logic       resetb;
    logic       start;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       player_wins, dealer_wins, done;

    logic       auto_feed;
    logic       f_valid, m_valid;
    logic [3:0] f_card, m_card;

    int   checks = 0;
    int   failures = 0;
    int   hands_done = 0;
    exp_t exp_q[$];
    int   feed[$];

    baccarat_dealer_if #(.CARD_W(4)) dif ();

    assign dif.card_valid = auto_feed ? f_valid : m_valid;
    assign dif.card_in    = auto_feed ? f_card  : m_card;

    baccarat_dealer #(.CARD_W(4), .FACE_MIN(10)) dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .start       (start),
        .deck        (dif),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .player_wins (player_wins),
        .dealer_wins (dealer_wins),
        .done        (done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pv(input int c);
        return (c >= 10) ? 0 : c;
    endfunction

    // Plays one hand of punto banco from the top of the deck.
    function automatic exp_t model(input int deck[6]);
        exp_t e;
        int   pt, bt, t;
        bit   bdraw;
        e = '{default: 0};
        e.p1 = deck[0]; e.d1 = deck[1]; e.p2 = deck[2]; e.d2 = deck[3];
        e.used = 4;
        pt = (pv(e.p1) + pv(e.p2)) % 10;
        bt = (pv(e.d1) + pv(e.d2)) % 10;
        bdraw = 0;
        if (pt < 8 && bt < 8) begin
            if (pt <= 5) begin
                e.p3 = deck[e.used];
                e.used = e.used + 1;
                t = pv(e.p3);
                if (bt <= 2)      bdraw = 1;
                else if (bt == 3) bdraw = (t != 8);
                else if (bt == 4) bdraw = (t inside {[2:7]});
                else if (bt == 5) bdraw = (t inside {[4:7]});
                else if (bt == 6) bdraw = (t inside {6, 7});
            end else begin
                bdraw = (bt <= 5);
            end
            if (bdraw) begin
                e.d3 = deck[e.used];
                e.used = e.used + 1;
            end
        end
        e.ps = (pv(e.p1) + pv(e.p2) + pv(e.p3)) % 10;
        e.ds = (pv(e.d1) + pv(e.d2) + pv(e.d3)) % 10;
        e.pw = (e.ps >= e.ds) ? 1 : 0;
        e.dw = (e.ds >= e.ps) ? 1 : 0;
        return e;
    endfunction

    // Deck source: stalls and junk codes are mixed in between real cards.
    initial begin
        int r, b;
        bit offer_real, req_n;
        f_valid = 1'b0;
        f_card  = 4'd0;
        forever begin
            @(negedge slow_clock);
            req_n = dif.card_req;
            offer_real = 0;
            r = $urandom_range(0, 9);
            if (!auto_feed || feed.size() == 0 || r < 2) begin
                f_valid = 1'b0;
                f_card  = 4'($urandom_range(0, 15));
            end else if (r < 4) begin
                b = $urandom_range(0, 2);
                f_valid = 1'b1;
                f_card  = (b == 0) ? 4'd0 : (b == 1) ? 4'd14 : 4'd15;
            end else begin
                f_valid = 1'b1;
                f_card  = 4'(feed[0]);
                offer_real = 1;
            end
            @(posedge slow_clock);
            if (offer_real && req_n) void'(feed.pop_front());
        end
    end

    // Monitor: every rising done is matched against the oldest predicted hand.
    initial begin
        bit   prev_done;
        exp_t e;
        prev_done = 0;
        forever begin
            @(negedge slow_clock);
            if (done && !prev_done) begin
                hands_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pcard1", int'(pcard1), e.p1);
                    check("pcard2", int'(pcard2), e.p2);
                    check("pcard3", int'(pcard3), e.p3);
                    check("dcard1", int'(dcard1), e.d1);
                    check("dcard2", int'(dcard2), e.d2);
                    check("dcard3", int'(dcard3), e.d3);
                    check("pscore", int'(pscore), e.ps);
                    check("dscore", int'(dscore), e.ds);
                    check("player_wins", int'(player_wins), e.pw);
                    check("dealer_wins", int'(dealer_wins), e.dw);
                    check("card_req_at_done", int'(dif.card_req), 0);
                end
            end
            prev_done = done;
        end
    end

    task automatic pulse_start();
        @(negedge slow_clock);
        start = 1'b1;
        @(negedge slow_clock);
        start = 1'b0;
    endtask

    task automatic run_hand(input int deck[6]);
        exp_t e;
        int   target;
        bit   seen;
        e = model(deck);
        exp_q.push_back(e);
        for (int i = 0; i < e.used; i++) feed.push_back(deck[i]);
        target = hands_done + 1;
        auto_feed = 1'b1;
        pulse_start();
        seen = 0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(negedge slow_clock);
            if (hands_done >= target) seen = 1;
        end
        check("hand_completes", int'(seen), 1);
        if (!seen) begin
            exp_q.delete();
            feed.delete();
        end
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_pcard1"}, int'(pcard1), 0);
        check({tag, "_pcard2"}, int'(pcard2), 0);
        check({tag, "_dcard1"}, int'(dcard1), 0);
        check({tag, "_pscore"}, int'(pscore), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_player_wins"}, int'(player_wins), 0);
        check({tag, "_dealer_wins"}, int'(dealer_wins), 0);
    endtask

    initial begin
        int deck[6];
        resetb    = 1'b0;
        start     = 1'b0;
        auto_feed = 1'b0;
        m_valid   = 1'b0;
        m_card    = 4'd0;

        repeat (2) @(negedge slow_clock);
        check_all_clear("reset");
        check("reset_card_req", int'(dif.card_req), 0);
        resetb = 1'b1;

        deck = '{9, 2, 9, 4, 0, 0};   run_hand(deck);
        deck = '{2, 13, 3, 3, 8, 0};  run_hand(deck);
        deck = '{4, 1, 3, 4, 9, 0};   run_hand(deck);
        deck = '{1, 6, 1, 10, 6, 2};  run_hand(deck);

        // Junk codes and stalls in DEAL_P1, start ignored mid-hand, async reset.
        auto_feed = 1'b0;
        pulse_start();
        m_valid = 1'b1; m_card = 4'd0;
        @(negedge slow_clock);
        check("junk0_pcard1", int'(pcard1), 0);
        check("junk0_card_req", int'(dif.card_req), 1);
        m_card = 4'd15;
        @(negedge slow_clock);
        check("junk15_pcard1", int'(pcard1), 0);
        m_valid = 1'b0; m_card = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge slow_clock);
            check("stall_pcard1", int'(pcard1), 0);
            check("stall_card_req", int'(dif.card_req), 1);
        end
        m_valid = 1'b1;
        @(negedge slow_clock);
        check("accept_pcard1", int'(pcard1), 7);
        check("accept_dcard1_empty", int'(dcard1), 0);
        m_valid = 1'b0;
        pulse_start();
        check("start_ignored_pcard1", int'(pcard1), 7);
        m_valid = 1'b1; m_card = 4'd3;
        @(negedge slow_clock);
        check("d1_after_start", int'(dcard1), 3);
        m_card = 4'd5;
        @(negedge slow_clock);
        check("p2_loaded", int'(pcard2), 5);
        m_valid = 1'b0;
        #2 resetb = 1'b0;
        #1;
        check_all_clear("async_reset");
        check("async_reset_card_req", int'(dif.card_req), 0);
        @(negedge slow_clock);
        resetb = 1'b1;

        // start in DONE clears the finished hand at the next edge.
        deck = '{9, 2, 9, 4, 0, 0};
        run_hand(deck);
        auto_feed = 1'b0;
        pulse_start();
        check_all_clear("restart");
        check("restart_card_req", int'(dif.card_req), 1);
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;

        for (int h = 0; h < 40; h++) begin
            for (int i = 0; i < 6; i++) deck[i] = $urandom_range(1, 13);
            run_hand(deck);
        end

        repeat (3) @(negedge slow_clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
